// File: rtl/regfile_arbiter.sv
// regfile_arbiter
// Shares one single-port register file between two requesters (A and B).
// Each granted access is sequenced as GRANT -> ISSUE -> CAPTURE, so the
// register file sees exactly one WrEn or RdEn pulse per access. The registered
// RdData is forwarded to the owner together with a one-cycle ack.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   a_req/b_req         : transaction request, held until the matching ack
//   a_we/b_we           : 1 = write, 0 = read
//   a_addr/b_addr       : register address
//   a_wdata/b_wdata     : write data
//   a_ack/b_ack         : one-cycle completion pulse
//   a_rdata/b_rdata     : read result, updated only on the owner's read completion
//   rf_WrEn, rf_RdEn    : register-file enables (never both high)
//   rf_address          : register-file address (holds when idle)
//   rf_WrData           : register-file write data (holds when idle)
//   rf_RdData           : registered read data from the register file
module regfile_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              rf_WrEn,
    output logic              rf_RdEn,
    output logic [ADDR_W-1:0] rf_address,
    output logic [DATA_W-1:0] rf_WrData,
    input  logic [DATA_W-1:0] rf_RdData
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t            state, state_n;
    // ptr/owner: 0 = requester A, 1 = requester B
    logic              ptr, ptr_n;
    logic              owner, owner_n;
    logic              op_we, op_we_n;
    logic              rf_WrEn_n, rf_RdEn_n;
    logic [ADDR_W-1:0] rf_address_n;
    logic [DATA_W-1:0] rf_WrData_n;
    logic              a_ack_n, b_ack_n;
    logic [DATA_W-1:0] a_rdata_n, b_rdata_n;

    // A requester in its ack cycle is still showing req (it may already be
    // presenting its next command) but must not be re-granted until the
    // following cycle.
    logic elig_a, elig_b, grant_b;
    assign elig_a  = a_req & ~a_ack;
    assign elig_b  = b_req & ~b_ack;
    assign grant_b = elig_b & (~elig_a | ptr);

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            op_we      <= 1'b0;
            rf_WrEn    <= 1'b0;
            rf_RdEn    <= 1'b0;
            rf_address <= '0;
            rf_WrData  <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            owner      <= owner_n;
            op_we      <= op_we_n;
            rf_WrEn    <= rf_WrEn_n;
            rf_RdEn    <= rf_RdEn_n;
            rf_address <= rf_address_n;
            rf_WrData  <= rf_WrData_n;
            a_ack      <= a_ack_n;
            b_ack      <= b_ack_n;
            a_rdata    <= a_rdata_n;
            b_rdata    <= b_rdata_n;
        end
    end

    // Next-state and next-output logic. Enables and acks default low so each
    // is a single-cycle pulse; address, write data and rdata default to hold.
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        owner_n      = owner;
        op_we_n      = op_we;
        rf_WrEn_n    = 1'b0;
        rf_RdEn_n    = 1'b0;
        rf_address_n = rf_address;
        rf_WrData_n  = rf_WrData;
        a_ack_n      = 1'b0;
        b_ack_n      = 1'b0;
        a_rdata_n    = a_rdata;
        b_rdata_n    = b_rdata;

        case (state)
            IDLE: begin
                if (elig_a | elig_b) begin
                    owner_n      = grant_b;
                    op_we_n      = grant_b ? b_we : a_we;
                    rf_WrEn_n    = grant_b ? b_we : a_we;
                    rf_RdEn_n    = grant_b ? ~b_we : ~a_we;
                    rf_address_n = grant_b ? b_addr : a_addr;
                    rf_WrData_n  = grant_b ? b_wdata : a_wdata;
                    // Pointer always favours whoever did not win this grant.
                    ptr_n        = ~grant_b;
                    state_n      = ISSUE;
                end
            end
            ISSUE: begin
                state_n = CAPTURE;
            end
            CAPTURE: begin
                if (owner) begin
                    b_ack_n = 1'b1;
                    if (!op_we) b_rdata_n = rf_RdData;
                end else begin
                    a_ack_n = 1'b1;
                    if (!op_we) a_rdata_n = rf_RdData;
                end
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Two-port round-robin arbiter and sequencer that shares one 8x16 single-port register file between requesters A and B.
- Serialises each granted access into the register file's WrEn/RdEn/address/WrData protocol, captures the registered RdData, and returns an ack plus read data to the owner.
- Guarantees WrEn and RdEn are never asserted together.
- Sits between two datapath clients and the register file instance.

Parameters:
- DATA_W, 16, data width of requester and register-file data buses.
- ADDR_W, 3, register-file address width (2^ADDR_W entries).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- a_req  input  1  requester A transaction request, held until a_ack.
- a_we  input  1  A: 1 = write, 0 = read; stable while a_req is high.
- a_addr  input  ADDR_W  A register address; stable while a_req is high.
- a_wdata  input  DATA_W  A write data; stable while a_req is high.
- a_ack  output  1  A completion pulse, exactly one cycle.
- a_rdata  output  DATA_W  A read result, valid with a_ack for reads, held afterwards.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the A ports, for requester B.
- rf_WrEn  output  1  register-file write enable.
- rf_RdEn  output  1  register-file read enable.
- rf_address  output  ADDR_W  register-file address.
- rf_WrData  output  DATA_W  register-file write data.
- rf_RdData  input  DATA_W  register-file read data; registered, updated on the edge that sees RdEn=1 and WrEn=0.

Behaviour:
- FSM states: IDLE, ISSUE, CAPTURE. All outputs are registered.
- IDLE:
  - Eligible requesters are those with req=1, excluding any requester whose ack is high this cycle.
  - If there is no eligible requester, remain in IDLE.
  - Otherwise grant one requester on the next edge E1. At E1: latch owner, we, addr and wdata into the rf_* registers; set rf_WrEn=we and rf_RdEn=!we; go to ISSUE.
- ISSUE (one cycle): the register file performs the operation at edge E2. At E2: clear rf_WrEn and rf_RdEn; go to CAPTURE.
- CAPTURE (one cycle): rf_RdData now holds the read value. At E3:
  - Pulse the owner's ack to 1 for exactly one cycle.
  - If the operation was a read, load the owner's rdata from rf_RdData.
  - Go to IDLE.
- Latency: a request sampled at edge E0 gives ack high in the cycle after E3. Peak throughput is 1 access per 4 cycles.
- Arbitration:
  - A 1-bit round-robin pointer selects which requester wins when both are eligible.
  - After any grant, the pointer moves to the non-granted requester.
  - A single eligible requester always wins regardless of the pointer.
  - Reset value of the pointer = A.
- Ack-cycle exclusion:
  - In its ack cycle a requester either drops req or presents its next transaction. It cannot be re-granted in that cycle.
  - The other requester may be granted in that cycle.
- Command capture: the command is latched at grant. Changes to a requester's addr/we/wdata, or dropping req, after grant do not affect the in-flight access. The access always completes and is acked (dropping req early is a protocol violation, but harmless).
- rdata hold: a requester's rdata changes only on that requester's read completion. Writes and the other requester's reads leave it untouched.
- rf_address and rf_WrData hold their last values when idle.
- Reset values (async, immediate on rst=1, including mid-transaction):
  - State = IDLE, pointer = A.
  - rf_WrEn = 0, rf_RdEn = 0, rf_address = 0, rf_WrData = 0.
  - a_ack = 0, b_ack = 0, a_rdata = 0, b_rdata = 0.
  - An in-flight access is abandoned with no ack. A write already clocked into the register file stays written.

Test Plan:
- Reset then idle: assert rst mid-ISSUE of an A write -> rf_WrEn falls to 0 without waiting for a clock edge, no a_ack ever, all outputs 0; with no req for 10 cycles, rf_WrEn and rf_RdEn stay 0.
- A single write then read: A writes addr 3 = 0xBEEF, then reads addr 3 -> a_ack in the 4th cycle after each request is sampled; a_rdata = 0xBEEF; rf_WrEn and rf_RdEn are never both 1.
- Simultaneous requests after reset: A writes 0x1111 to addr 1 and B writes 0x2222 to addr 1, same cycle -> A served first, then B; a subsequent read of addr 1 returns 0x2222.
- Continuous contention: A and B both hold req for 8 transactions each -> grants alternate A, B, A, B…; no requester is starved; every transaction is acked exactly once.
- Back-to-back single requester: B keeps req high through its ack with a new address each time (reads of addr 0..7 after writes of 0x0100*i) -> one ack every 4 cycles; b_rdata = 0x0000, 0x0100, … 0x0700; a_rdata stays 0.
- Late input change: after grant, A changes a_addr from 5 to 6 and drops a_req -> access still goes to addr 5 and a_ack still pulses once.
